// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: widths, funct3 codes, FSM states, fault check.
package lsu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    // True when a request can never touch memory: bad funct3, misaligned, or beyond the array.
    function automatic logic req_faults(input logic            we,
                                        input logic [2:0]      f3,
                                        input logic [XLEN-1:0] addr,
                                        input int unsigned     mem_words);
        logic legal;
        logic misaligned;
        logic out_of_range;
        if (we) begin
            legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end else begin
            legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                    (f3 == F3_BU) || (f3 == F3_HU);
        end
        misaligned   = ((f3[1:0] == 2'b01) && addr[0]) ||
                       ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        out_of_range = {2'b00, addr[XLEN-1:2]} >= XLEN'(mem_words);
        return !legal || misaligned || out_of_range;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: load extraction/extension and sub-word store merge into a memory word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] word,
    input  logic [15:0]     wdata,
    output logic [XLEN-1:0] load_data_c,
    output logic [XLEN-1:0] store_word_c
);

    logic [4:0]      byte_sh;
    logic [4:0]      half_sh;
    logic [7:0]      byte_val;
    logic [15:0]     half_val;
    logic [XLEN-1:0] byte_mask;
    logic [XLEN-1:0] half_mask;

    // Select the addressed lane, then extend for loads or splice in new data for stores.
    always_comb begin
        byte_sh      = {addr_lo, 3'b000};
        half_sh      = {addr_lo[1], 4'b0000};
        byte_val     = 8'(word >> byte_sh);
        half_val     = 16'(word >> half_sh);
        byte_mask    = XLEN'(32'h0000_00FF) << byte_sh;
        half_mask    = XLEN'(32'h0000_FFFF) << half_sh;
        load_data_c  = '0;
        store_word_c = word;
        case (funct3)
            F3_B: begin
                load_data_c  = {{24{byte_val[7]}}, byte_val};
                store_word_c = (word & ~byte_mask) |
                               ((XLEN'(wdata[7:0]) << byte_sh) & byte_mask);
            end
            F3_H: begin
                load_data_c  = {{16{half_val[15]}}, half_val};
                store_word_c = (word & ~half_mask) |
                               ((XLEN'(wdata) << half_sh) & half_mask);
            end
            F3_W:    load_data_c = word;
            F3_BU:   load_data_c = {24'h00_0000, byte_val};
            F3_HU:   load_data_c = {16'h0000, half_val};
            default: load_data_c = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one request at a time, word accesses, read-modify-write for SB/SH.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_fault,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_write_data,
    output logic            mem_write,
    output logic            mem_read,
    input  logic [XLEN-1:0] mem_read_data
);

    lsu_state_e      state_q, state_d;
    logic            we_q, we_d;
    logic [2:0]      f3_q, f3_d;
    logic [1:0]      addr_lo_q, addr_lo_d;
    logic [15:0]     wdata_q, wdata_d;

    logic            req_ready_q, req_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
    logic            rsp_fault_q, rsp_fault_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] mem_write_data_q, mem_write_data_d;
    logic            mem_write_q, mem_write_d;
    logic            mem_read_q, mem_read_d;

    logic            req_fault_c;
    logic [XLEN-1:0] word_idx_c;
    logic [XLEN-1:0] load_data_c;
    logic [XLEN-1:0] store_word_c;

    lsu_align u_align (
        .funct3       (f3_q),
        .addr_lo      (addr_lo_q),
        .word         (mem_read_data),
        .wdata        (wdata_q),
        .load_data_c  (load_data_c),
        .store_word_c (store_word_c)
    );

    assign req_ready      = req_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_fault      = rsp_fault_q;
    assign mem_addr       = mem_addr_q;
    assign mem_write_data = mem_write_data_q;
    assign mem_write      = mem_write_q;
    assign mem_read       = mem_read_q;

    // Next state and next-cycle outputs; outputs are derived from the state being entered.
    always_comb begin
        state_d          = state_q;
        we_d             = we_q;
        f3_d             = f3_q;
        addr_lo_d        = addr_lo_q;
        wdata_d          = wdata_q;
        req_ready_d      = 1'b0;
        rsp_valid_d      = 1'b0;
        rsp_rdata_d      = '0;
        rsp_fault_d      = 1'b0;
        mem_addr_d       = '0;
        mem_write_data_d = '0;
        mem_write_d      = 1'b0;
        mem_read_d       = 1'b0;
        req_fault_c      = req_faults(req_we, req_funct3, req_addr, MEM_WORDS);
        word_idx_c       = {2'b00, req_addr[XLEN-1:2]};

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d      = req_we;
                    f3_d      = req_funct3;
                    addr_lo_d = req_addr[1:0];
                    wdata_d   = req_wdata[15:0];
                    if (req_fault_c) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_fault_d = 1'b1;
                    end else if (req_we && (req_funct3 == F3_W)) begin
                        state_d          = WRITE;
                        mem_write_d      = 1'b1;
                        mem_addr_d       = word_idx_c;
                        mem_write_data_d = req_wdata;
                    end else begin
                        state_d    = READ;
                        mem_read_d = 1'b1;
                        mem_addr_d = word_idx_c;
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            READ: begin
                if (we_q) begin
                    state_d          = WRITE;
                    mem_write_d      = 1'b1;
                    mem_addr_d       = mem_addr_q;
                    mem_write_data_d = store_word_c;
                end else begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = load_data_c;
                end
            end
            WRITE: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
            end
            RESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    // State, captured request fields and registered outputs; reset aborts any access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= IDLE;
            we_q             <= 1'b0;
            f3_q             <= 3'b000;
            addr_lo_q        <= 2'b00;
            wdata_q          <= 16'h0000;
            req_ready_q      <= 1'b1;
            rsp_valid_q      <= 1'b0;
            rsp_rdata_q      <= '0;
            rsp_fault_q      <= 1'b0;
            mem_addr_q       <= '0;
            mem_write_data_q <= '0;
            mem_write_q      <= 1'b0;
            mem_read_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            we_q             <= we_d;
            f3_q             <= f3_d;
            addr_lo_q        <= addr_lo_d;
            wdata_q          <= wdata_d;
            req_ready_q      <= req_ready_d;
            rsp_valid_q      <= rsp_valid_d;
            rsp_rdata_q      <= rsp_rdata_d;
            rsp_fault_q      <= rsp_fault_d;
            mem_addr_q       <= mem_addr_d;
            mem_write_data_q <= mem_write_data_d;
            mem_write_q      <= mem_write_d;
            mem_read_q       <= mem_read_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: data-memory model, request-level reference model, per-cycle compare.
module tb_load_store_unit;

    localparam int MEM_WORDS = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_read_data;

    logic [31:0] dmem    [0:MEM_WORDS-1];
    logic [31:0] ref_mem [0:MEM_WORDS-1];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rsp_count = 0;
    int acc_count = 0;
    int last_acc = 0;
    logic [31:0] last_rdata = 32'h0;
    logic        last_fault = 1'b0;
    int          last_lat = 0;

    typedef struct {
        int          acc;
        int          due;
        int          rd_cyc;
        int          wr_cyc;
        logic [31:0] idx;
        logic [31:0] wword;
        logic [31:0] rd;
        logic        fault;
        logic        upd;
    } exp_t;

    exp_t expq[$];

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_fault      (rsp_fault),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    // Data memory: combinational read, write on the clock edge.
    assign mem_read_data = (mem_addr < 32'(MEM_WORDS)) ? dmem[mem_addr[5:0]] : 32'h0;
    always @(posedge clk) begin
        if (mem_write && (mem_addr < 32'(MEM_WORDS))) dmem[mem_addr[5:0]] <= mem_write_data;
    end

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: what one accepted request must do, from the RV32I rules.
    function automatic exp_t model_req(input logic we, input logic [2:0] f3,
                                       input logic [31:0] addr, input logic [31:0] wd,
                                       input int acc);
        exp_t e;
        logic [7:0]  b [4];
        logic [31:0] w;
        logic        legal;
        int          a;
        int          sz;
        e.acc = acc; e.rd_cyc = -1; e.wr_cyc = -1; e.idx = 0; e.wword = 0;
        e.rd = 0; e.upd = 1'b0;
        legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        sz    = 1 << f3[1:0];
        a     = int'(addr[1:0]);
        e.fault = !legal || ((a % sz) != 0) || ((addr >> 2) >= 32'(MEM_WORDS));
        if (e.fault) begin
            e.due = acc;
            return e;
        end
        e.idx = addr >> 2;
        w = ref_mem[e.idx[5:0]];
        for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
        if (!we) begin
            e.rd_cyc = acc;
            e.due    = acc + 1;
            case (sz)
                1:       e.rd = f3[2] ? {24'h0, b[a]} : {{24{b[a][7]}}, b[a]};
                2:       e.rd = f3[2] ? {16'h0, b[a+1], b[a]} : {{16{b[a+1][7]}}, b[a+1], b[a]};
                default: e.rd = w;
            endcase
        end else begin
            e.upd = 1'b1;
            if (sz == 4) begin
                e.wr_cyc = acc;
                e.due    = acc + 1;
                e.wword  = wd;
            end else begin
                e.rd_cyc = acc;
                e.wr_cyc = acc + 1;
                e.due    = acc + 2;
                b[a] = wd[7:0];
                if (sz == 2) b[a+1] = wd[15:8];
                e.wword = {b[3], b[2], b[1], b[0]};
            end
        end
        return e;
    endfunction

    // Cycle counter and accept monitor feeding the expectation queue.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset && req_valid && req_ready) begin
            expq.push_back(model_req(req_we, req_funct3, req_addr, req_wdata, cyc + 1));
            acc_count <= acc_count + 1;
            last_acc  <= cyc + 1;
        end
    end

    task automatic compare_cycle();
        exp_t h;
        logic have;
        logic er;
        logic ew;
        have = (expq.size() != 0);
        if (have) h = expq[0];
        er = have && (cyc == h.rd_cyc);
        ew = have && (cyc == h.wr_cyc);
        chk32("mem_read", 32'(mem_read), 32'(er));
        chk32("mem_write", 32'(mem_write), 32'(ew));
        chk32("req_ready", 32'(req_ready), 32'(!have));
        if (er || ew) begin
            chk32("mem_addr", mem_addr, h.idx);
        end else begin
            chk32("mem_addr_idle", mem_addr, 32'h0);
            chk32("mem_write_data_idle", mem_write_data, 32'h0);
        end
        if (ew) chk32("mem_write_data", mem_write_data, h.wword);
        if (rsp_valid) begin
            if (!have) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: rsp_valid=1 with nothing outstanding, expected 0 (cycle %0d)", cyc);
            end else begin
                chk32("rsp_cycle", 32'(cyc), 32'(h.due));
                chk32("rsp_rdata", rsp_rdata, h.rd);
                chk32("rsp_fault", 32'(rsp_fault), 32'(h.fault));
                last_rdata = rsp_rdata;
                last_fault = rsp_fault;
                last_lat   = cyc - h.acc + 1;
                if (h.upd) ref_mem[h.idx[5:0]] = h.wword;
                void'(expq.pop_front());
                rsp_count++;
            end
        end else begin
            chk32("rsp_rdata_idle", rsp_rdata, 32'h0);
            chk32("rsp_fault_idle", 32'(rsp_fault), 32'h0);
            if (have && (cyc >= h.due)) begin
                checks++;
                errors++;
                $display("FAIL missing_rsp: rsp_valid=0, expected 1 at cycle %0d", h.due);
                void'(expq.pop_front());
            end
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (reset) compare_cycle();
    end

    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd);
        int n;
        int rc0;
        @(negedge clk);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk32("accept_wait", 32'(req_ready), 32'h1);
        rc0 = rsp_count;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        while (rsp_count == rc0 && n < 10) begin
            @(posedge clk);
            #1 n++;
        end
        chk32("rsp_wait", 32'(rsp_count != rc0), 32'h1);
    endtask

    task automatic load_chk(input string name, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] exp);
        send(1'b0, f3, addr, 32'h0);
        chk32(name, last_rdata, exp);
        chk32({name, "_lat"}, 32'(last_lat), 32'd2);
    endtask

    task automatic fault_chk(input string name, input logic we, input logic [2:0] f3,
                             input logic [31:0] addr);
        send(we, f3, addr, 32'hFFFF_FFFF);
        chk32(name, 32'(last_fault), 32'h1);
        chk32({name, "_rdata"}, last_rdata, 32'h0);
        chk32({name, "_lat"}, 32'(last_lat), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a1;
        int c1;
        int n;
        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk32("rst_req_ready", 32'(req_ready), 32'h1);
        chk32("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk32("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk32("rst_rsp_fault", 32'(rsp_fault), 32'h0);
        chk32("rst_mem_rw", {30'h0, mem_read, mem_write}, 32'h0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chk32("rst_mem_wdata", mem_write_data, 32'h0);
        reset = 1'b1;

        // Fill words through the unit with SW.
        send(1'b1, 3'b010, 32'h14, 32'h8000_00F0);
        chk32("sw_lat", 32'(last_lat), 32'd2);
        chk32("sw_rdata", last_rdata, 32'h0);
        send(1'b1, 3'b010, 32'h08, 32'h1234_80FF);
        send(1'b1, 3'b010, 32'h0C, 32'hAABB_CCDD);
        send(1'b1, 3'b010, 32'h1C, 32'h0102_0304);

        load_chk("lw_w5",   3'b010, 32'h14, 32'h8000_00F0);
        load_chk("lb_0x08", 3'b000, 32'h08, 32'hFFFF_FFFF);
        load_chk("lbu_0x09", 3'b100, 32'h09, 32'h0000_0080);
        load_chk("lh_0x0a", 3'b001, 32'h0A, 32'h0000_1234);
        load_chk("lhu_0x08", 3'b101, 32'h08, 32'h0000_80FF);
        load_chk("lh_0x08", 3'b001, 32'h08, 32'hFFFF_80FF);

        send(1'b1, 3'b000, 32'h0D, 32'h0000_0011);
        chk32("sb_lat", 32'(last_lat), 32'd3);
        chk32("sb_fault", 32'(last_fault), 32'h0);
        load_chk("lw_after_sb", 3'b010, 32'h0C, 32'hAABB_11DD);
        send(1'b1, 3'b001, 32'h0E, 32'h0000_5566);
        chk32("sh_lat", 32'(last_lat), 32'd3);
        load_chk("lw_after_sh", 3'b010, 32'h0C, 32'h5566_11DD);
        load_chk("lbu_0x0f", 3'b100, 32'h0F, 32'h0000_0055);

        fault_chk("f_lw_misal", 1'b0, 3'b010, 32'h06);
        fault_chk("f_sh_misal", 1'b1, 3'b001, 32'h03);
        fault_chk("f_lw_range", 1'b0, 3'b010, 32'h100);
        fault_chk("f_ld_f3_011", 1'b0, 3'b011, 32'h00);
        fault_chk("f_st_f3_100", 1'b1, 3'b100, 32'h00);
        fault_chk("f_lhu_misal", 1'b0, 3'b101, 32'h01);

        // Back-to-back SW with req_valid held high.
        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h28; req_wdata = 32'hCAFE_0001;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 a1 = last_acc;
        c1 = acc_count;
        req_addr = 32'h2C; req_wdata = 32'h0BAD_0002;
        n = 0;
        while (acc_count == c1 && n < 10) begin
            @(posedge clk);
            #1 n++;
        end
        req_valid = 1'b0;
        chk32("b2b_accept_gap", 32'(last_acc - a1), 32'd3);
        repeat (4) @(posedge clk);
        load_chk("lw_b2b_0", 3'b010, 32'h28, 32'hCAFE_0001);
        load_chk("lw_b2b_1", 3'b010, 32'h2C, 32'h0BAD_0002);

        // Reset during the read phase of an SH.
        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h1E; req_wdata = 32'h0000_BEEF;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        #1 chk32("mid_sh_read", 32'(mem_read), 32'h1);
        #1 reset = 1'b0;
        expq.delete();
        #1;
        chk32("abort_req_ready", 32'(req_ready), 32'h1);
        chk32("abort_mem_rw", {30'h0, mem_read, mem_write}, 32'h0);
        chk32("abort_mem_addr", mem_addr, 32'h0);
        chk32("abort_rsp", {31'h0, rsp_valid} | 32'(rsp_fault) | rsp_rdata, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (6) @(posedge clk);
        #1 chk32("abort_word7", dmem[7], 32'h0102_0304);
        load_chk("lw_after_abort", 3'b010, 32'h1C, 32'h0102_0304);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
